multicycle_ctrl: RTL and testbench

//  Parametrised multi-cycle control unit for the attopu core; successor to the combinational decoder.

---
 rtl/attopu_pkg.sv | 44 ++++
 rtl/ir_field_extract.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/attopu_pkg.sv
// attopu_pkg
//   Shared encodings for the attopu multi-cycle control unit: opcodes,
//   controller states, PC-select and write-back source codes, and ALU
//   function codes.
package attopu_pkg;

  // Opcodes live in the top three bits of every instruction
  localparam logic [2:0] OP_ALU     = 3'b000;
  localparam logic [2:0] OP_LDI     = 3'b001;
  localparam logic [2:0] OP_JMP     = 3'b010;
  localparam logic [2:0] OP_LD      = 3'b011;
  localparam logic [2:0] OP_HALT    = 3'b100;
  localparam logic [2:0] OP_ST      = 3'b101;
  localparam logic [2:0] OP_BRZ_REL = 3'b110;
  localparam logic [2:0] OP_BRZ_REG = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // pc_sel encodings
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] PC_ABS = 2'b11;

  // reg_src encodings
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_MEM = 2'b10;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_fn_t;

endpackage

// File: rtl/ir_field_extract.sv
// ir_field_extract
//   Purely combinational slicing of the instruction register into opcode,
//   register indices and the extended immediate.
// Ports:
//   ir   in   DATA_W  latched instruction
//   op   out  3       opcode
//   rd   out  REG_W   destination register index
//   rs1  out  REG_W   first source register index
//   rs2  out  REG_W   second source register index
//   imm  out  DATA_W  immediate, sign-extended for BRZ rel, zero-extended otherwise
module ir_field_extract
  import attopu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 2
) (
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        op,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [DATA_W-1:0] imm
);

  localparam int IMM_W = DATA_W - 3;

  logic [IMM_W-1:0] imm_field;

  assign op        = ir[DATA_W-1 -: 3];
  assign rd        = ir[DATA_W-4 -: REG_W];
  assign rs1       = ir[DATA_W-4-REG_W -: REG_W];
  assign rs2       = ir[DATA_W-4-2*REG_W -: REG_W];
  assign imm_field = ir[IMM_W-1:0];

  // Only the relative branch needs a signed offset; everything else
  // treats the field as an unsigned constant or absolute target.
  assign imm = (op == OP_BRZ_REL) ? {{3{imm_field[IMM_W-1]}}, imm_field}
                                  : {3'b000, imm_field};

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control unit for the attopu core. Latches each fetched
//   instruction in an IR and sequences IDLE/FETCH/DECODE/EXEC/MEM/HALT,
//   driving the regfile, ALU and PC strobes plus memory handshakes.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   imem_req/ack/rdata     instruction fetch handshake
//   dmem_req/we/ack        data access handshake (we valid while req)
//   zflag                  ALU zero flag, sampled in DECODE
//   pc_we, pc_sel          PC update strobe and next-PC source
//   imm, rd, rs1, rs2      IR fields
//   reg_we, reg_src        regfile write strobe and write-back source
//   alu_fn                 ALU function
//   halted                 core stopped after HALT
module multicycle_ctrl
  import attopu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 2,
  parameter int ALUF_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic              zflag,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [DATA_W-1:0] imm,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic              reg_we,
  output logic [1:0]        reg_src,
  output logic [ALUF_W-1:0] alu_fn,
  output logic              halted
);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] ir;
  logic              zf_q;
  logic [2:0]        op;

  ir_field_extract #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_fields (
    .ir (ir),
    .op (op),
    .rd (rd),
    .rs1(rs1),
    .rs2(rs2),
    .imm(imm)
  );

  // IR only loads on a completed fetch handshake, and the zero flag is
  // captured in DECODE so a flag change during EXEC cannot alter a branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
      zf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
      end
      if (state == S_DECODE) begin
        zf_q <= zflag;
      end
    end
  end

  // Next-state and strobe decode. The MEM completion strobes follow
  // dmem_ack in the same cycle because load data is only valid while the
  // ack is high, and this keeps LD/ST at four cycles with zero-wait memory.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_INC;
    reg_we   = 1'b0;
    reg_src  = SRC_ALU;
    alu_fn   = ALUF_W'(ALU_ADD);
    halted   = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        case (op)
          OP_ALU: begin
            reg_we  = 1'b1;
            reg_src = SRC_ALU;
            alu_fn  = ir[ALUF_W-1:0];
            pc_we   = 1'b1;
          end
          OP_LDI: begin
            reg_we  = 1'b1;
            reg_src = SRC_IMM;
            pc_we   = 1'b1;
          end
          OP_JMP: begin
            pc_we  = 1'b1;
            pc_sel = PC_ABS;
          end
          OP_BRZ_REL: begin
            pc_we = 1'b1;
            if (zf_q) begin
              pc_sel = PC_REL;
            end
          end
          OP_BRZ_REG: begin
            pc_we = 1'b1;
            if (zf_q) begin
              pc_sel = PC_REG;
            end
          end
          OP_LD, OP_ST: state_nx = S_MEM;
          OP_HALT:      state_nx = S_HALT;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (dmem_ack) begin
          pc_we    = 1'b1;
          state_nx = S_FETCH;
          if (op == OP_LD) begin
            reg_we  = 1'b1;
            reg_src = SRC_MEM;
          end
        end
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl: a default 16-bit instance and a
//   24-bit / 3-bit-register instance. Inputs change on the falling edge,
//   outputs are sampled shortly after.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_ack;
  logic        zflag;
  logic        imem_req, dmem_req, dmem_we, pc_we, reg_we, halted;
  logic [1:0]  pc_sel, reg_src, alu_fn;
  logic [15:0] imm;
  logic [1:0]  rd, rs1, rs2;

  logic        imem_ack_w;
  logic [23:0] imem_rdata_w;
  logic        imem_req_w, dmem_req_w, dmem_we_w, pc_we_w, reg_we_w, halted_w;
  logic [1:0]  pc_sel_w, reg_src_w, alu_fn_w;
  logic [23:0] imm_w;
  logic [2:0]  rd_w, rs1_w, rs2_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .zflag(zflag), .pc_we(pc_we), .pc_sel(pc_sel), .imm(imm),
    .rd(rd), .rs1(rs1), .rs2(rs2), .reg_we(reg_we), .reg_src(reg_src),
    .alu_fn(alu_fn), .halted(halted)
  );

  multicycle_ctrl #(.DATA_W(24), .REG_W(3), .ALUF_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
    .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_ack(1'b0),
    .zflag(1'b0), .pc_we(pc_we_w), .pc_sel(pc_sel_w), .imm(imm_w),
    .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .reg_we(reg_we_w), .reg_src(reg_src_w),
    .alu_fn(alu_fn_w), .halted(halted_w)
  );

  // Present an instruction with a zero-wait ack; returns in DECODE with
  // zflag driven for the DECODE sample.
  task automatic issue(input logic [15:0] instr, input logic zf_decode);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    zflag    = zf_decode;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; zflag = 1'b0;
    imem_ack_w = 1'b0; imem_rdata_w = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_req: got %0b expected 0", imem_req); end
    checks++; if ({dmem_req, pc_we, reg_we, halted} !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {dmem_req, pc_we, reg_we, halted}); end
    checks++; if (imm !== 16'h0) begin errors++; $display("[TB] FAIL reset_imm: got %h expected 0000", imm); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_imem_req: got %0b expected 0", imem_req); end
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_imem_req: got %0b expected 1", imem_req); end
  endtask

  task automatic test_ldi();
    issue(16'h2005, 1'b0);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ldi_decode_req: got %0b expected 0", imem_req); end
    checks++; if (imm !== 16'h0005) begin errors++; $display("[TB] FAIL ldi_decode_imm: got %h expected 0005", imm); end
    @(negedge clk); #1;
    checks++; if (reg_we !== 1'b1) begin errors++; $display("[TB] FAIL ldi_reg_we: got %0b expected 1", reg_we); end
    checks++; if (reg_src !== 2'b01) begin errors++; $display("[TB] FAIL ldi_reg_src: got %b expected 01", reg_src); end
    checks++; if (imm !== 16'h0005) begin errors++; $display("[TB] FAIL ldi_imm: got %h expected 0005", imm); end
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'b00) begin errors++; $display("[TB] FAIL ldi_pc: got we=%0b sel=%b expected we=1 sel=00", pc_we, pc_sel); end
    @(negedge clk); #1;
    checks++; if ({imem_req, reg_we, pc_we} !== 3'b100) begin errors++; $display("[TB] FAIL ldi_back_to_fetch: got %b expected 100", {imem_req, reg_we, pc_we}); end
  endtask

  task automatic test_alu();
    issue(16'h1B03, 1'b0);
    #1;
    checks++; if ({rd, rs1, rs2} !== 6'b11_01_10) begin errors++; $display("[TB] FAIL alu_fields: got rd=%0d rs1=%0d rs2=%0d expected 3 1 2", rd, rs1, rs2); end
    @(negedge clk); #1;
    checks++; if (reg_we !== 1'b1 || reg_src !== 2'b00) begin errors++; $display("[TB] FAIL alu_wb: got we=%0b src=%b expected we=1 src=00", reg_we, reg_src); end
    checks++; if (alu_fn !== 2'd3) begin errors++; $display("[TB] FAIL alu_fn: got %0d expected 3", alu_fn); end
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'b00) begin errors++; $display("[TB] FAIL alu_pc: got we=%0b sel=%b expected we=1 sel=00", pc_we, pc_sel); end
    @(negedge clk); #1;
  endtask

  task automatic test_branch();
    issue(16'hDFFE, 1'b1);
    @(negedge clk); zflag = 1'b0; #1;
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'b01) begin errors++; $display("[TB] FAIL brz_taken_pc: got we=%0b sel=%b expected we=1 sel=01", pc_we, pc_sel); end
    checks++; if (imm !== 16'hFFFE) begin errors++; $display("[TB] FAIL brz_sext_imm: got %h expected fffe", imm); end
    @(negedge clk); #1;
    issue(16'hC7FE, 1'b0);
    @(negedge clk); zflag = 1'b1; #1;
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'b00) begin errors++; $display("[TB] FAIL brz_not_taken_pc: got we=%0b sel=%b expected we=1 sel=00", pc_we, pc_sel); end
    checks++; if (imm !== 16'h07FE) begin errors++; $display("[TB] FAIL brz_pos_imm: got %h expected 07fe", imm); end
    @(negedge clk); #1;
    issue(16'hE200, 1'b1);
    @(negedge clk); zflag = 1'b0; #1;
    checks++; if (pc_sel !== 2'b10 || rs1 !== 2'd1) begin errors++; $display("[TB] FAIL brz_reg: got sel=%b rs1=%0d expected sel=10 rs1=1", pc_sel, rs1); end
    @(negedge clk); #1;
    issue(16'h4123, 1'b0);
    @(negedge clk); #1;
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'b11 || reg_we !== 1'b0) begin errors++; $display("[TB] FAIL jmp_pc: got we=%0b sel=%b reg_we=%0b expected 1 11 0", pc_we, pc_sel, reg_we); end
    checks++; if (imm !== 16'h0123) begin errors++; $display("[TB] FAIL jmp_imm: got %h expected 0123", imm); end
    @(negedge clk); #1;
  endtask

  task automatic test_ld();
    issue(16'h7200, 1'b0);
    #1;
    checks++; if (rd !== 2'd2 || rs1 !== 2'd1) begin errors++; $display("[TB] FAIL ld_fields: got rd=%0d rs1=%0d expected 2 1", rd, rs1); end
    @(negedge clk); #1;
    checks++; if ({pc_we, reg_we, dmem_req} !== 3'b000) begin errors++; $display("[TB] FAIL ld_exec_quiet: got %b expected 000", {pc_we, reg_we, dmem_req}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL ld_wait%0d_req: got req=%0b we=%0b expected 1 0", i, dmem_req, dmem_we); end
      checks++; if (reg_we !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("[TB] FAIL ld_wait%0d_strobes: got reg_we=%0b pc_we=%0b expected 0 0", i, reg_we, pc_we); end
    end
    @(negedge clk); dmem_ack = 1'b1; #1;
    checks++; if (reg_we !== 1'b1 || reg_src !== 2'b10) begin errors++; $display("[TB] FAIL ld_ack_wb: got we=%0b src=%b expected 1 10", reg_we, reg_src); end
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'b00) begin errors++; $display("[TB] FAIL ld_ack_pc: got we=%0b sel=%b expected 1 00", pc_we, pc_sel); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    checks++; if ({imem_req, dmem_req, reg_we} !== 3'b100) begin errors++; $display("[TB] FAIL ld_next_fetch: got %b expected 100", {imem_req, dmem_req, reg_we}); end
  endtask

  task automatic test_st();
    logic reg_we_seen;
    reg_we_seen = 1'b0;
    imem_rdata = 16'hA580;
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      reg_we_seen |= reg_we;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL st_fetch_wait%0d_req: got %0b expected 1", i, imem_req); end
      checks++; if (imm !== 16'h1200 || rd !== 2'd2) begin errors++; $display("[TB] FAIL st_ir_hold%0d: got imm=%h rd=%0d expected 1200 2", i, imm, rd); end
      @(negedge clk);
    end
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0; #1;
    reg_we_seen |= reg_we;
    checks++; if (rs1 !== 2'd2 || rs2 !== 2'd3 || imm !== 16'h0580) begin errors++; $display("[TB] FAIL st_fields: got rs1=%0d rs2=%0d imm=%h expected 2 3 0580", rs1, rs2, imm); end
    @(negedge clk); #1;
    reg_we_seen |= reg_we;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL st_mem_req: got req=%0b we=%0b expected 1 1", dmem_req, dmem_we); end
    dmem_ack = 1'b1; #1;
    reg_we_seen |= reg_we;
    checks++; if (pc_we !== 1'b1) begin errors++; $display("[TB] FAIL st_ack_pc_we: got %0b expected 1", pc_we); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    reg_we_seen |= reg_we;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL st_next_fetch: got %0b expected 1", imem_req); end
    checks++; if (reg_we_seen !== 1'b0) begin errors++; $display("[TB] FAIL st_no_reg_we: got %0b expected 0", reg_we_seen); end
  endtask

  task automatic test_halt();
    logic bad;
    bad = 1'b0;
    issue(16'h8000, 1'b0);
    @(negedge clk); #1;
    checks++; if (pc_we !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_exec: got pc_we=%0b halted=%0b expected 0 0", pc_we, halted); end
    @(negedge clk); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %0b expected 1", halted); end
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0 || dmem_req !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL halt_sticky: got disturbance=%0b expected 0", bad); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset: got halted=%0b imem_req=%0b expected 0 0", halted, imem_req); end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_handshake();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    issue(16'h7200, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_mem_req: got %0b expected 1", dmem_req); end
    dmem_ack = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({dmem_req, reg_we, pc_we} !== 3'b000) begin errors++; $display("[TB] FAIL mid_mem_reset_strobes: got %b expected 000", {dmem_req, reg_we, pc_we}); end
    checks++; if (rd !== 2'd0 || imm !== 16'h0) begin errors++; $display("[TB] FAIL mid_mem_reset_ir: got rd=%0d imm=%h expected 0 0000", rd, imm); end
    dmem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    imem_rdata = 16'h2005; imem_ack = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_fetch_reset_req: got %0b expected 0", imem_req); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imm !== 16'h0) begin errors++; $display("[TB] FAIL mid_fetch_ack_dropped: got req=%0b imm=%h expected 1 0000", imem_req, imm); end
    imem_ack = 1'b0;
  endtask

  task automatic test_param_sweep();
    imem_rdata_w = 24'h1EE001;
    imem_ack_w = 1'b1;
    @(negedge clk); imem_ack_w = 1'b0; #1;
    checks++; if (rd_w !== 3'd7 || rs1_w !== 3'd5 || rs2_w !== 3'd6) begin errors++; $display("[TB] FAIL wide_fields: got rd=%0d rs1=%0d rs2=%0d expected 7 5 6", rd_w, rs1_w, rs2_w); end
    checks++; if ({reg_we_w, dmem_req_w, dmem_we_w, halted_w} !== 4'b0) begin errors++; $display("[TB] FAIL wide_decode_quiet: got %b expected 0000", {reg_we_w, dmem_req_w, dmem_we_w, halted_w}); end
    @(negedge clk); #1;
    checks++; if (reg_we_w !== 1'b1 || reg_src_w !== 2'b00 || alu_fn_w !== 2'd1) begin errors++; $display("[TB] FAIL wide_exec: got we=%0b src=%b fn=%0d expected 1 00 1", reg_we_w, reg_src_w, alu_fn_w); end
    checks++; if (pc_we_w !== 1'b1 || pc_sel_w !== 2'b00 || imm_w !== 24'h1EE001) begin errors++; $display("[TB] FAIL wide_exec_pc: got we=%0b sel=%b imm=%h expected 1 00 1ee001", pc_we_w, pc_sel_w, imm_w); end
    @(negedge clk); #1;
    checks++; if (reg_we_w !== 1'b0 || imem_req_w !== 1'b1) begin errors++; $display("[TB] FAIL wide_pulse_end: got reg_we=%0b imem_req=%0b expected 0 1", reg_we_w, imem_req_w); end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu();
    test_branch();
    test_ld();
    test_st();
    test_halt();
    test_reset_mid_handshake();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
